// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and defaults for the completion path.
// The tag layout is {phys_reg, ready}; consumers qualify every field with cdb_en.
package cdb_arbiter_pkg;

  localparam int NUM_FU_DEF = 4;
  localparam int PREG_W_DEF = 6;
  localparam int ROB_W_DEF  = 5;
  localparam int XLEN_DEF   = 32;

  typedef struct packed {
    logic [PREG_W_DEF-1:0] phys_reg;
    logic                  ready;
  } TAG;

  typedef struct packed {
    TAG                   tag;
    logic [ROB_W_DEF-1:0] rob_idx;
    logic [XLEN_DEF-1:0]  value;
  } CDB_PACKET;

  typedef struct packed {
    logic      valid;
    CDB_PACKET pkt;
  } FU_CMPL_PACKET;

  function automatic int popcount32(logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: first set req at ptr, ptr+1, ... (mod N); 0 when idle.
// Purely combinational, no backpressure of its own.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;

  // Walk offsets from farthest to nearest so the closest requester overwrites.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-unit holding registers drained one per cycle round-robin; handshake to cdb_en is 2 cycles.
// A unit sees fu_ready low while its holding register is full and not granted, and during interrupt.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int PREG_W = PREG_W_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int XLEN   = XLEN_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          interrupt,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU*PREG_W-1:0]      fu_preg,
  input  logic [NUM_FU*ROB_W-1:0]       fu_rob_idx,
  input  logic [NUM_FU*XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]             fu_ready,
  output logic                          cdb_en,
  output logic [PREG_W:0]               cdb,
  output logic [ROB_W-1:0]              cdb_rob_idx,
  output logic [XLEN-1:0]               cdb_value,
  output logic [$clog2(NUM_FU+1)-1:0]   pending_cnt
);

  localparam int PTR_W = $clog2(NUM_FU);
  localparam int CNT_W = $clog2(NUM_FU + 1);

  logic [NUM_FU-1:0] hold_v;
  logic [NUM_FU-1:0] hold_v_nxt;
  logic [NUM_FU-1:0] arb_grant;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] load;
  logic [PREG_W-1:0] hold_preg  [NUM_FU];
  logic [ROB_W-1:0]  hold_rob   [NUM_FU];
  logic [XLEN-1:0]   hold_value [NUM_FU];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [PREG_W-1:0] win_preg;
  logic [ROB_W-1:0]  win_rob;
  logic [XLEN-1:0]   win_value;

  rr_arbiter #(.N(NUM_FU), .PW(PTR_W)) u_rr (
    .req   (hold_v),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  // A granted slot frees up this cycle, so it may be refilled on the same edge.
  assign grant      = interrupt ? '0 : arb_grant;
  assign fu_ready   = interrupt ? '0 : (~hold_v | grant);
  assign load       = fu_valid & fu_ready;
  assign hold_v_nxt = interrupt ? '0 : ((hold_v & ~grant) | load);

  always_comb begin
    win_idx   = '0;
    win_preg  = '0;
    win_rob   = '0;
    win_value = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        win_idx   = PTR_W'(i);
        win_preg  = hold_preg[i];
        win_rob   = hold_rob[i];
        win_value = hold_value[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_v      <= '0;
      rr_ptr      <= '0;
      cdb_en      <= 1'b0;
      cdb         <= '0;
      cdb_rob_idx <= '0;
      cdb_value   <= '0;
      pending_cnt <= '0;
    end else begin
      hold_v      <= hold_v_nxt;
      pending_cnt <= CNT_W'(popcount32(32'(hold_v_nxt)));
      cdb_en      <= |grant;
      if (interrupt) begin
        rr_ptr <= '0;
      end else if (|grant) begin
        rr_ptr      <= (win_idx == PTR_W'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
        cdb         <= {win_preg, 1'b1};
        cdb_rob_idx <= win_rob;
        cdb_value   <= win_value;
      end
    end
  end

  // Payload is only observed through a set hold_v, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (load[i]) begin
        hold_preg[i]  <= fu_preg[i*PREG_W +: PREG_W];
        hold_rob[i]   <= fu_rob_idx[i*ROB_W +: ROB_W];
        hold_value[i] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: fixed vectors, directed corner sequences and random traffic
// against a distance-based round-robin model with a value-keyed scoreboard.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int PW = 6;
  localparam int RW = 5;
  localparam int XW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            interrupt;
  logic [N-1:0]    fu_valid;
  logic [N*PW-1:0] fu_preg;
  logic [N*RW-1:0] fu_rob_idx;
  logic [N*XW-1:0] fu_value;
  logic [N-1:0]    fu_ready;
  logic            cdb_en;
  logic [PW:0]     cdb;
  logic [RW-1:0]   cdb_rob_idx;
  logic [XW-1:0]   cdb_value;
  logic [2:0]      pending_cnt;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_FU(N), .PREG_W(PW), .ROB_W(RW), .XLEN(XW)) dut (
    .clock       (clock),
    .reset       (reset),
    .interrupt   (interrupt),
    .fu_valid    (fu_valid),
    .fu_preg     (fu_preg),
    .fu_rob_idx  (fu_rob_idx),
    .fu_value    (fu_value),
    .fu_ready    (fu_ready),
    .cdb_en      (cdb_en),
    .cdb         (cdb),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_value   (cdb_value),
    .pending_cnt (pending_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] s_preg [N];
  logic [RW-1:0] s_rob  [N];
  logic [XW-1:0] s_val  [N];

  // Reference state: occupied slots, pointer, last broadcast.
  bit            m_v    [N];
  logic [PW-1:0] m_preg [N];
  logic [RW-1:0] m_rob  [N];
  logic [XW-1:0] m_val  [N];
  int            m_ptr;
  bit            m_en;
  bit            m_tagrdy;
  logic [PW-1:0] m_opreg;
  logic [RW-1:0] m_orob;
  logic [XW-1:0] m_oval;

  int            sb [bit [31:0]];
  int            stepn = 0;
  int            acc_cnt = 0;
  logic [N-1:0]  obs_rdy;
  logic [PW-1:0] bq [$];
  TAG            t_obs;

  typedef struct {
    logic [N-1:0]    v;
    logic [N*PW-1:0] pregs;
    logic [N-1:0]    rdy;
    logic            en;
    logic [PW-1:0]   preg;
    logic [2:0]      cnt;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) m_v[j] = 1'b0;
    m_ptr = 0; m_en = 1'b0; m_tagrdy = 1'b0;
    m_opreg = '0; m_orob = '0; m_oval = '0;
    sb.delete();
  endtask

  task automatic step(input logic [N-1:0] v, input bit intr);
    int g, best, d, cnt, lat;
    logic [N-1:0] er;
    @(negedge clock);
    fu_valid  = v;
    interrupt = intr;
    for (int j = 0; j < N; j++) begin
      fu_preg[j*PW +: PW]    = s_preg[j];
      fu_rob_idx[j*RW +: RW] = s_rob[j];
      fu_value[j*XW +: XW]   = s_val[j];
    end
    // Winner is the occupied slot at the smallest forward distance from the pointer.
    g = -1; best = N;
    if (!intr) begin
      for (int j = 0; j < N; j++) begin
        if (m_v[j]) begin
          d = (j - m_ptr + N) % N;
          if (d < best) begin best = d; g = j; end
        end
      end
    end
    for (int j = 0; j < N; j++) er[j] = !intr && (!m_v[j] || g == j);
    #1;
    obs_rdy = fu_ready;
    check("fu_ready", fu_ready, er);
    @(posedge clock);
    #1;
    stepn++;
    if (intr) begin
      for (int j = 0; j < N; j++) m_v[j] = 1'b0;
      m_ptr = 0; m_en = 1'b0;
      sb.delete();
    end else begin
      if (g >= 0) begin
        m_en = 1'b1; m_tagrdy = 1'b1;
        m_opreg = m_preg[g]; m_orob = m_rob[g]; m_oval = m_val[g];
        m_v[g] = 1'b0;
        m_ptr = (g + 1) % N;
      end else begin
        m_en = 1'b0;
      end
      for (int j = 0; j < N; j++) begin
        if (v[j] && er[j]) begin
          m_v[j] = 1'b1; m_preg[j] = s_preg[j]; m_rob[j] = s_rob[j]; m_val[j] = s_val[j];
          sb[s_val[j]] = stepn;
          acc_cnt++;
        end
      end
    end
    cnt = 0;
    for (int j = 0; j < N; j++) cnt += int'(m_v[j]);
    check("cdb_out", {cdb_en, cdb, cdb_rob_idx, cdb_value}, {m_en, m_opreg, m_tagrdy, m_orob, m_oval});
    check("pending_cnt", pending_cnt, cnt);
    if (cdb_en === 1'b1) begin
      bq.push_back(cdb[PW:1]);
      checks++;
      if (!sb.exists(cdb_value)) begin
        errors++;
        $display("FAIL sb_lookup: got value %0h expected a pending completion", cdb_value);
      end else begin
        lat = stepn - sb[cdb_value];
        if (lat < 1 || lat > N) begin
          errors++;
          $display("FAIL starvation: got latency %0d expected 1..%0d", lat, N);
        end
        sb.delete(cdb_value);
      end
    end
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) step('0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    fu_valid = '0; interrupt = 1'b0; reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int dups, acc0;
    reset = 1'b1; interrupt = 1'b0; fu_valid = '0;
    fu_preg = '0; fu_rob_idx = '0; fu_value = '0;
    for (int j = 0; j < N; j++) begin s_preg[j] = '0; s_rob[j] = '0; s_val[j] = '0; end
    model_reset();
    #12;
    check("reset_cdb", {cdb_en, cdb, cdb_rob_idx, cdb_value}, 64'd0);
    check("reset_cnt", pending_cnt, 0);
    check("reset_ready", fu_ready, 4'hF);
    reset = 1'b0;

    // All-unit collision drained in order from pointer 0.
    tbl[0] = '{v: 4'hF, pregs: {6'd8, 6'd7, 6'd6, 6'd5}, rdy: 4'hF, en: 1'b0, preg: 6'd0, cnt: 3'd4};
    tbl[1] = '{v: 4'h0, pregs: '0, rdy: 4'b0001, en: 1'b1, preg: 6'd5, cnt: 3'd3};
    tbl[2] = '{v: 4'h0, pregs: '0, rdy: 4'b0011, en: 1'b1, preg: 6'd6, cnt: 3'd2};
    tbl[3] = '{v: 4'h0, pregs: '0, rdy: 4'b0111, en: 1'b1, preg: 6'd7, cnt: 3'd1};
    tbl[4] = '{v: 4'h0, pregs: '0, rdy: 4'b1111, en: 1'b1, preg: 6'd8, cnt: 3'd0};
    tbl[5] = '{v: 4'h0, pregs: '0, rdy: 4'b1111, en: 1'b0, preg: 6'd0, cnt: 3'd0};
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < N; j++) begin
        s_preg[j] = tbl[r].pregs[j*PW +: PW];
        s_rob[j]  = RW'(j);
        s_val[j]  = 32'hA000_0000 + 32'(tbl[r].pregs[j*PW +: PW]);
      end
      step(tbl[r].v, 1'b0);
      check("tbl_ready", obs_rdy, tbl[r].rdy);
      check("tbl_en", cdb_en, tbl[r].en);
      if (tbl[r].en) check("tbl_preg", cdb[PW:1], tbl[r].preg);
      check("tbl_cnt", pending_cnt, tbl[r].cnt);
    end

    // Single completion, broadcast exactly once two cycles after the handshake.
    s_preg[0] = 6'd12; s_rob[0] = 5'd3; s_val[0] = 32'hDEAD_BEEF;
    step(4'b0001, 1'b0);
    check("t1_en_c1", cdb_en, 1'b0);
    step('0, 1'b0);
    check("t1_bcast", {cdb_en, cdb, cdb_rob_idx, cdb_value}, {1'b1, 6'd12, 1'b1, 5'd3, 32'hDEAD_BEEF});
    t_obs = cdb;
    check("t1_tag_ready", t_obs.ready, 1'b1);
    step('0, 1'b0);
    check("t1_en_c3", cdb_en, 1'b0);

    // Units 0 and 3 continuously valid, pointer now at 1.
    bq.delete();
    for (int n = 0; n < 8; n++) begin
      s_preg[0] = 6'd40; s_preg[3] = 6'd43;
      s_val[0] = 32'hC000_0000 + 32'(2 * n);
      s_val[3] = 32'hC000_0001 + 32'(2 * n);
      step(4'b1001, 1'b0);
    end
    drain(4);
    check("t4_count", bq.size(), 9);
    if (bq.size() >= 4) begin
      for (int k = 0; k < 4; k++) check("t4_order", bq[k], (k % 2 == 0) ? 6'd43 : 6'd40);
    end

    // Unit 1 streams while units 0 and 2 are pending.
    bq.delete();
    acc0 = acc_cnt;
    s_preg[0] = 6'd10; s_preg[2] = 6'd11; s_preg[1] = 6'd20;
    s_val[0] = 32'hB100_0000; s_val[2] = 32'hB200_0000; s_val[1] = 32'hB000_0000;
    step(4'b0111, 1'b0);
    for (int n = 1; n < 7; n++) begin
      s_preg[1] = 6'(20 + n);
      s_val[1]  = 32'hB000_0000 + 32'(n);
      step(4'b0010, 1'b0);
    end
    drain(5);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_count", bq.size(), acc_cnt - acc0);
    dups = 0;
    for (int a = 0; a < bq.size(); a++)
      for (int b = a + 1; b < bq.size(); b++)
        if (bq[a] == bq[b]) dups++;
    check("t3_dup", dups, 0);

    // Interrupt flush while entries are still pending.
    do_reset();
    for (int j = 0; j < 3; j++) begin s_preg[j] = 6'(50 + j); s_val[j] = 32'hD000_0000 + 32'(j); end
    step(4'b0111, 1'b0);
    step('0, 1'b0);
    check("t5_first", cdb_en, 1'b1);
    s_preg[3] = 6'd55; s_val[3] = 32'hD000_0010;
    step(4'b1000, 1'b1);
    check("t5_ready_intr", obs_rdy, 4'b0000);
    check("t5_en", cdb_en, 1'b0);
    check("t5_cnt", pending_cnt, 0);
    bq.delete();
    drain(3);
    check("t5_quiet", bq.size(), 0);
    s_preg[0] = 6'd60; s_preg[2] = 6'd62;
    s_val[0] = 32'hD000_0020; s_val[2] = 32'hD000_0022;
    step(4'b0101, 1'b0);
    step('0, 1'b0);
    check("t5_ptr0", cdb[PW:1], 6'd60);
    drain(2);

    // Asynchronous reset between edges with entries in flight.
    s_preg[0] = 6'd70; s_preg[1] = 6'd71;
    s_val[0] = 32'hE000_0000; s_val[1] = 32'hE000_0001;
    step(4'b0011, 1'b0);
    step('0, 1'b0);
    check("t6_pre_en", cdb_en, 1'b1);
    check("t6_pre_cnt", pending_cnt, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_en", cdb_en, 1'b0);
    check("t6_async_cnt", pending_cnt, 0);
    model_reset();
    reset = 1'b0;
    drain(2);

    // Random traffic with occasional flushes, including preg 0.
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < N; j++) begin
        s_preg[j] = 6'($urandom_range(0, 63));
        s_rob[j]  = 5'($urandom_range(0, 31));
        s_val[j]  = 32'h1000_0000 + 32'(n * 4 + j);
      end
      step(4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
    end
    drain(N + 1);
    check("rand_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
